alu_seq_n: RTL and testbench

//  Parametrised, registered successor to the 4-bit switch ALU: WIDTH-bit operands A/B and an opcode.

---
 rtl/alu_seq_n_pkg.sv | 21 ++
 rtl/alu_seq_n_ripple_carry.sv | 30 +++
 rtl/alu_seq_n.sv | 163 ++++++++++++++++
 tb/tb_alu_seq_n.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_n_pkg.sv
// Package for the sequential ALU.
// Holds the opcode encodings and the controller state type shared by
// alu_seq_n and anything that drives or observes it.
package alu_seq_n_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_ORXOR = 3'b010;
  localparam logic [2:0] OP_ROR   = 3'b011;
  localparam logic [2:0] OP_RAND  = 3'b100;
  localparam logic [2:0] OP_CAT   = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  // IDLE accepts requests; MUL runs the shift-add multiplier.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_n_ripple_carry.sv
// ripple_carry_n: parametrised ripple-carry adder.
// Ports:
//   a, b  in  WIDTH  addends
//   cin   in  1      carry in
//   s     out WIDTH  sum
//   cout  out 1      carry out
// The carry chain is a local variable walked bit by bit, which keeps the
// chain out of a self-referencing vector.
module ripple_carry_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  always_comb begin : chain
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/alu_seq_n.sv
// alu_seq_n: registered WIDTH-bit ALU with a start/busy/done handshake.
// Ports:
//   clk      in   1        clock, rising edge
//   reset    in   1        asynchronous active-high reset
//   start    in   1        request, accepted on a clock edge while busy=0
//   op       in   3        opcode, sampled with start
//   a, b     in   WIDTH    operands, sampled with start
//   acc_sel  in   1        1: use result[WIDTH-1:0] as the B operand
//   result   out  2*WIDTH  registered result, held until the next completion
//   carry    out  1        ADD carry-out / SUB borrow, 0 otherwise
//   zero     out  1        result == 0, registered with result
//   busy     out  1        multiply in progress (controller is in ST_MUL)
//   done     out  1        one-cycle pulse after result/flags update
// Handshake: a request is taken on any rising edge where start=1 and
// busy=0; single-cycle ops complete at that edge and done is high for the
// following cycle, MUL completes WIDTH edges later. start while busy is
// dropped, never queued. done and busy are never high together.
module alu_seq_n
  import alu_seq_n_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               acc_sel,
  output logic [2*WIDTH-1:0] result,
  output logic               carry,
  output logic               zero,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q;        // latched multiplicand
  logic [WIDTH-1:0]   mq;         // multiplier, shifted right each step
  logic [2*WIDTH-1:0] prod;       // partial product
  logic [CNT_W-1:0]   cnt;        // multiply steps completed

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH-1:0]   add_a, add_b, add_s;
  logic               add_cin, add_cout;
  logic [2*WIDTH-1:0] op_result;
  logic               op_carry;
  logic [2*WIDTH-1:0] mul_next;
  logic               last_step;

  assign b_eff = acc_sel ? result[WIDTH-1:0] : b;

  // One adder serves ADD/SUB while idle and the partial-sum step while
  // multiplying; SUB is A + ~B + 1.
  always_comb begin
    add_a   = a;
    add_b   = b_eff;
    add_cin = 1'b0;
    if (state == ST_MUL) begin
      add_a = prod[2*WIDTH-1:WIDTH];
      add_b = mq[0] ? a_q : '0;
    end else if (op == OP_SUB) begin
      add_b   = ~b_eff;
      add_cin = 1'b1;
    end
  end

  ripple_carry_n #(.WIDTH(WIDTH)) u_adder (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .s   (add_s),
    .cout(add_cout)
  );

  // Right-shifting shift-add: the adder's carry becomes the new top bit and
  // the low half collects finished product bits.
  assign mul_next  = {add_cout, add_s, prod[WIDTH-1:1]};
  assign last_step = (state == ST_MUL) && (cnt == CNT_W'(WIDTH - 1));

  // Single-cycle op results.
  always_comb begin
    op_result = '0;
    op_carry  = 1'b0;
    case (op)
      OP_ADD: begin
        op_result = {{(WIDTH-1){1'b0}}, add_cout, add_s};
        op_carry  = add_cout;
      end
      OP_SUB: begin
        op_result = {{WIDTH{1'b0}}, add_s};
        op_carry  = ~add_cout;  // no carry out of A + ~B + 1 means A < B
      end
      OP_ORXOR: op_result = {a | b_eff, a ^ b_eff};
      OP_ROR:   op_result = {{(2*WIDTH-1){1'b0}}, |{a, b_eff}};
      OP_RAND:  op_result = {{(2*WIDTH-1){1'b0}}, &{a, b_eff}};
      OP_CAT:   op_result = {a, b_eff};
      default:  op_result = '0;  // MUL goes through the FSM; RSVD yields 0
    endcase
  end

  // Controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start && op == OP_MUL) state_nxt = ST_MUL;
      ST_MUL:  if (last_step)             state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_MUL);

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
      done   <= 1'b0;
      a_q    <= '0;
      mq     <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          if (op == OP_MUL) begin
            a_q  <= a;
            mq   <= b_eff;
            prod <= '0;
            cnt  <= '0;
          end else begin
            result <= op_result;
            carry  <= op_carry;
            zero   <= (op_result == '0);
            done   <= 1'b1;
          end
        end
      end else begin
        prod <= mul_next;
        mq   <= mq >> 1;
        cnt  <= cnt + CNT_W'(1);
        if (last_step) begin
          result <= mul_next;
          carry  <= 1'b0;
          zero   <= (mul_next == '0);
          done   <= 1'b1;
          cnt    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Testbench for alu_seq_n at WIDTH=4: vector table, hand-written
// multi-cycle sequences and randomized ops against a behavioural model.
module tb_alu_seq_n;

  localparam int W = 4;

  localparam logic [2:0] T_ADD = 3'd0, T_SUB = 3'd1, T_ORXOR = 3'd2, T_ROR = 3'd3;
  localparam logic [2:0] T_RAND = 3'd4, T_CAT = 3'd5, T_MUL = 3'd6, T_RSVD = 3'd7;

  logic           clk, reset, start, acc_sel;
  logic [2:0]     op;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] result;
  logic           carry, zero, busy, done;

  int total = 0;
  int bad   = 0;

  logic [2*W:0]   exp_q[$];   // {carry, result} per issued operation
  logic [2*W-1:0] model_res;  // last completed result, for acc_sel

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           acc;
    logic [2*W-1:0] res;
    logic           cy;
  } vec_t;

  vec_t vecs[16];

  alu_seq_n #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .acc_sel(acc_sel),
    .result (result),
    .carry  (carry),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // done and busy must never overlap
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (busy && done) begin
        bad++;
        $display("FAIL busy_done_overlap act=1 exp=0");
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the opcode rules.
  function automatic void model(input logic [2:0] mop, input int ma, input int mb,
                                output logic [2*W-1:0] res, output logic cy);
    int m, r;
    m = 1 << W;
    r = 0;
    cy = 1'b0;
    case (mop)
      T_ADD:   begin r = ma + mb; cy = (ma + mb) >= m; end
      T_SUB:   begin r = (ma - mb + m) % m; cy = ma < mb; end
      T_ORXOR: r = (ma | mb) * m + (ma ^ mb);
      T_ROR:   r = (ma != 0 || mb != 0) ? 1 : 0;
      T_RAND:  r = (ma == m - 1 && mb == m - 1) ? 1 : 0;
      T_CAT:   r = ma * m + mb;
      T_MUL:   r = ma * mb;
      default: r = 0;
    endcase
    res = r[2*W-1:0];
  endfunction

  // Driver: issue one op (inputs change #1 after an edge), wait for its
  // completion with a bound, then score it.
  task automatic run_op(input logic [2:0] top, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tacc, input logic [2*W-1:0] eres, input logic ecy);
    int n, busy_cnt;
    logic [2*W:0] e;
    n = 0;
    while (busy && n < 20) begin @(posedge clk); #1; n++; end
    exp_q.push_back({ecy, eres});
    op = top; a = ta; b = tb; acc_sel = tacc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 16'(n), (top == T_MUL) ? 16'(W) : 16'd0);
    check("busy_cycles", 16'(busy_cnt), (top == T_MUL) ? 16'(W) : 16'd0);
    e = exp_q.pop_front();
    check("result", 16'(result), 16'(e[2*W-1:0]));
    check("carry", 16'(carry), 16'(e[2*W]));
    check("zero", 16'(zero), 16'(e[2*W-1:0] == '0));
    model_res = eres;
    @(posedge clk); #1;
    check("done_drop", 16'(done), 16'd0);
    check("result_hold", 16'(result), 16'(eres));
  endtask

  initial begin
    logic [2*W-1:0] mres;
    logic           mcy;
    logic [W-1:0]   ra, rb, beff;
    logic [2:0]     rop;
    logic           racc;
    int n, dones;

    vecs[0]  = '{T_ADD,   4'hF, 4'h1, 1'b0, 8'h10, 1'b1};
    vecs[1]  = '{T_SUB,   4'h3, 4'h5, 1'b0, 8'h0E, 1'b1};
    vecs[2]  = '{T_ORXOR, 4'hC, 4'hA, 1'b0, 8'hE6, 1'b0};
    vecs[3]  = '{T_CAT,   4'hC, 4'hA, 1'b0, 8'hCA, 1'b0};
    vecs[4]  = '{T_ROR,   4'h0, 4'h0, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{T_RAND,  4'hF, 4'hF, 1'b0, 8'h01, 1'b0};
    vecs[6]  = '{T_MUL,   4'hF, 4'hF, 1'b0, 8'hE1, 1'b0};
    vecs[7]  = '{T_RSVD,  4'h7, 4'h7, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{T_SUB,   4'h5, 4'h3, 1'b0, 8'h02, 1'b0};
    vecs[9]  = '{T_ADD,   4'h7, 4'h8, 1'b0, 8'h0F, 1'b0};
    vecs[10] = '{T_RAND,  4'hF, 4'hE, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{T_ROR,   4'h0, 4'h1, 1'b0, 8'h01, 1'b0};
    vecs[12] = '{T_MUL,   4'h3, 4'h5, 1'b0, 8'h0F, 1'b0};
    vecs[13] = '{T_MUL,   4'h0, 4'h9, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{T_ADD,   4'h2, 4'h3, 1'b0, 8'h05, 1'b0};
    vecs[15] = '{T_ADD,   4'h4, 4'hF, 1'b1, 8'h09, 1'b0};  // B = previous 05

    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; acc_sel = 1'b0;
    model_res = '0;

    // Reset clears outputs before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_result", 16'(result), 16'h0);
    check("rst_zero", 16'(zero), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_carry", 16'(carry), 16'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 16; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].res, vecs[i].cy);

    // Reset mid-cycle after a nonzero result
    run_op(T_ADD, 4'h3, 4'h4, 1'b0, 8'h07, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_result", 16'(result), 16'h0);
    check("mid_rst_zero", 16'(zero), 16'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_res = '0;

    // Back-to-back single-cycle ops with start held high
    op = T_ADD; a = 4'h1; b = 4'h2; acc_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    check("b2b_done1", 16'(done), 16'h1);
    check("b2b_res1", 16'(result), 16'h03);
    op = T_SUB; a = 4'h9; b = 4'h4;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done2", 16'(done), 16'h1);
    check("b2b_res2", 16'(result), 16'h05);
    @(posedge clk); #1;
    check("b2b_done_drop", 16'(done), 16'h0);

    // Start during MUL is ignored: single done, result E1
    op = T_MUL; a = 4'hF; b = 4'hF; acc_sel = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    op = T_ADD; a = 4'h1; b = 4'h1;
    n = 0;
    while (!done && n < 20) begin @(posedge clk); #1; n++; end
    start = 1'b0;
    check("ign_latency", 16'(n), 16'(W));
    check("ign_result", 16'(result), 16'hE1);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("ign_extra_done", 16'(dones), 16'h0);
    check("ign_result_hold", 16'(result), 16'hE1);
    model_res = 8'hE1;

    // Reset in the third MUL cycle aborts without a done
    run_op(T_ADD, 4'h3, 4'h4, 1'b0, 8'h07, 1'b0);
    op = T_MUL; a = 4'h7; b = 4'h6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_busy_before", 16'(busy), 16'h1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 16'(busy), 16'h0);
    check("abort_result", 16'(result), 16'h0);
    check("abort_zero", 16'(zero), 16'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_res = '0;
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("abort_no_done", 16'(dones), 16'h0);
    run_op(T_ADD, 4'h1, 4'h1, 1'b0, 8'h02, 1'b0);

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = 4'($urandom_range(0, 15));
      rb   = 4'($urandom_range(0, 15));
      racc = 1'($urandom_range(0, 1));
      beff = racc ? model_res[W-1:0] : rb;
      model(rop, int'(ra), int'(beff), mres, mcy);
      run_op(rop, ra, rb, racc, mres, mcy);
      for (int k = $urandom_range(0, 2); k > 0; k--) begin @(posedge clk); #1; end
    end

    check("exp_q_empty", 16'(exp_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
